// File: rtl/unidad_de_riesgos.sv
// Hazard-detection and pipeline-tracking unit: tracks destination registers of EXE/MEM/WB,
// stalls on load-use, freezes on slow data memory and flushes on a taken branch.
module unidad_de_riesgos #(
  parameter int ANCHO_REG  = 4,
  parameter int ANCHO_CNT  = 4,
  parameter int MAX_ESPERA = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ANCHO_REG-1:0] RG_id,
  input  logic [ANCHO_REG-1:0] RP_id,
  input  logic [ANCHO_REG-1:0] RS_id,
  input  logic                 usa_RP_id,
  input  logic                 usa_RS_id,
  input  logic                 escribe_id,
  input  logic                 carga_id,
  input  logic                 mem_listo,
  input  logic                 salto_tomado,
  output logic [ANCHO_REG-1:0] RG_exe,
  output logic [ANCHO_REG-1:0] RG_mem,
  output logic [ANCHO_REG-1:0] RG_wb,
  output logic                 prohib_exe,
  output logic                 prohib_mem,
  output logic                 prohib_wb,
  output logic                 detener_pc,
  output logic                 detener_if_id,
  output logic                 burbuja_id_ex,
  output logic                 limpiar_if_id,
  output logic                 congelar,
  output logic                 error_mem
);

  localparam logic [ANCHO_CNT-1:0] LIMITE = ANCHO_CNT'(MAX_ESPERA);

  logic [ANCHO_REG-1:0] rg_exe_r, rg_mem_r, rg_wb_r;
  logic                 prohib_exe_r, prohib_mem_r, prohib_wb_r;
  logic                 carga_exe_r, carga_mem_r;
  logic [ANCHO_CNT-1:0] cnt_r;
  logic                 error_r;

  logic congelar_s, salto_s, carga_uso_s, riesgo_raw_s;

  // Hazard decode with fixed priority: memory freeze, then branch flush, then load-use stall
  always_comb begin
    congelar_s   = 1'b0;
    salto_s      = 1'b0;
    carga_uso_s  = 1'b0;
    riesgo_raw_s = carga_exe_r & ~prohib_exe_r &
                   ((usa_RP_id & (RP_id == rg_exe_r)) | (usa_RS_id & (RS_id == rg_exe_r)));
    if (!rst) begin
      congelar_s  = carga_mem_r & ~prohib_mem_r & ~mem_listo;
      salto_s     = salto_tomado & ~congelar_s;
      carga_uso_s = riesgo_raw_s & ~congelar_s & ~salto_tomado;
    end else begin
      congelar_s  = 1'b0;
      salto_s     = 1'b0;
      carga_uso_s = 1'b0;
    end
  end

  assign congelar      = congelar_s;
  assign detener_pc    = congelar_s | carga_uso_s;
  assign detener_if_id = congelar_s | carga_uso_s;
  assign burbuja_id_ex = salto_s | carga_uso_s;
  assign limpiar_if_id = salto_s;

  // Stage trackers: hold while frozen, otherwise shift with a bubble injected into EXE on flush/stall
  always_ff @(posedge clk) begin
    if (rst) begin
      rg_exe_r     <= {ANCHO_REG{1'b0}};
      rg_mem_r     <= {ANCHO_REG{1'b0}};
      rg_wb_r      <= {ANCHO_REG{1'b0}};
      prohib_exe_r <= 1'b1;
      prohib_mem_r <= 1'b1;
      prohib_wb_r  <= 1'b1;
      carga_exe_r  <= 1'b0;
      carga_mem_r  <= 1'b0;
    end else if (congelar_s) begin
      rg_exe_r     <= rg_exe_r;
      rg_mem_r     <= rg_mem_r;
      rg_wb_r      <= rg_wb_r;
      prohib_exe_r <= prohib_exe_r;
      prohib_mem_r <= prohib_mem_r;
      prohib_wb_r  <= prohib_wb_r;
      carga_exe_r  <= carga_exe_r;
      carga_mem_r  <= carga_mem_r;
    end else begin
      rg_wb_r      <= rg_mem_r;
      prohib_wb_r  <= prohib_mem_r;
      rg_mem_r     <= rg_exe_r;
      prohib_mem_r <= prohib_exe_r;
      carga_mem_r  <= carga_exe_r;
      if (salto_s | carga_uso_s) begin
        rg_exe_r     <= {ANCHO_REG{1'b0}};
        prohib_exe_r <= 1'b1;
        carga_exe_r  <= 1'b0;
      end else begin
        rg_exe_r     <= RG_id;
        prohib_exe_r <= ~escribe_id;
        carga_exe_r  <= carga_id;
      end
    end
  end

  // Memory-wait counter (saturating) and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= {ANCHO_CNT{1'b0}};
      error_r <= 1'b0;
    end else if (congelar_s) begin
      if (cnt_r == LIMITE) begin
        cnt_r   <= cnt_r;
        error_r <= 1'b1;
      end else begin
        cnt_r   <= cnt_r + ANCHO_CNT'(1);
        error_r <= error_r;
      end
    end else begin
      cnt_r   <= {ANCHO_CNT{1'b0}};
      error_r <= error_r;
    end
  end

  assign RG_exe     = rg_exe_r;
  assign RG_mem     = rg_mem_r;
  assign RG_wb      = rg_wb_r;
  assign prohib_exe = prohib_exe_r;
  assign prohib_mem = prohib_mem_r;
  assign prohib_wb  = prohib_wb_r;
  assign error_mem  = error_r;

endmodule
